// File: rtl/hs_rx_fifo.sv
// Purpose: receive-side valid/ready slave buffering upstream words in a DEPTH-entry FIFO, with a sticky upstream protocol-violation flag.
// Latency: a word pushed in cycle N appears on out_valid/out_data in cycle N+1 (no bypass when empty).
// Backpressure: in_ready drops while full or during the reset-exit cycle, and depends only on registered state.
//
// Ports:
//   clk, reset_n          clock (rising edge); asynchronous active-low reset
//   in_valid/in_data      upstream word offered by the master
//   in_ready              slave ready back to the master
//   out_valid/out_data    head of FIFO toward the consumer (first-word fall-through)
//   out_ready             consumer ready
//   count                 current occupancy, 0..DEPTH
//   proto_err             sticky: master withdrew valid before it was accepted
module hs_rx_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  count,
  output logic              proto_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              ready_en;
  logic              stall_q;
  logic              push;
  logic              pop;

  // ready_en keeps in_ready low for the first cycle after reset release,
  // so nothing is pushed while the caller is still exiting reset.
  assign in_ready  = ready_en && (count != FULL_CNT);
  assign out_valid = (count != '0);
  assign out_data  = mem[rd_ptr];
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      ready_en  <= 1'b0;
      stall_q   <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      // Simultaneous push and pop leaves occupancy unchanged; when full,
      // in_ready is already low so push and pop cannot target one slot.
      if (push && !pop)
        count <= count + CNT_W'(1);
      else if (pop && !push)
        count <= count - CNT_W'(1);
      // A stalled offer must be held; dropping valid the cycle after a
      // stall is a master protocol violation.
      stall_q <= in_valid && !in_ready;
      if (stall_q && !in_valid) proto_err <= 1'b1;
    end
  end

  // Payload storage needs no reset: out_data is ignored while out_valid is low.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

endmodule

// File: tb/tb_hs_rx_fifo.sv
module tb_hs_rx_fifo;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready = 1'b0;
  logic [2:0]  count;
  logic        proto_err;

  hs_rx_fifo #(.DATA_W(32), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .count     (count),
    .proto_err (proto_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: a queue of accepted words plus a few flags.
  logic [31:0] sb[$];
  bit          m_ready_en = 0;
  bit          m_err = 0;
  bit          m_stall = 0;
  bit          pend_push = 0;
  bit          pend_err = 0;
  bit          pend_stall = 0;
  bit          acc = 0;
  bit          exp_rdy;
  logic [31:0] pend_data;
  bit          done;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: sampled mid-cycle, compares against the model and pops the scoreboard.
  always @(negedge clk) begin
    if (reset_n) begin
      exp_rdy = m_ready_en && (sb.size() < DEPTH);
      chk("in_ready", in_ready, exp_rdy);
      chk("count", count, sb.size());
      chk("out_valid", out_valid, sb.size() != 0);
      chk("proto_err", proto_err, m_err);
      pend_push  = in_valid && exp_rdy;
      pend_data  = in_data;
      pend_err   = m_stall && !in_valid;
      pend_stall = in_valid && !exp_rdy;
      if (sb.size() != 0) begin
        chk("out_data", out_data, sb[0]);
        if (out_ready) void'(sb.pop_front());
      end
    end
  end

  // Model state update at the clock edge; reset clears everything at once.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sb.delete();
      m_ready_en = 0; m_err = 0; m_stall = 0;
      pend_push = 0; pend_err = 0; pend_stall = 0; acc = 0;
    end else begin
      acc = pend_push;
      if (pend_push) sb.push_back(pend_data);
      if (pend_err) m_err = 1;
      m_stall    = pend_stall;
      m_ready_en = 1;
      pend_push = 0; pend_err = 0; pend_stall = 0;
    end
  end

  task automatic cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Master behaviour: hold the offer until accepted.
  task automatic send(input logic [31:0] d);
    int t = 0;
    in_valid = 1'b1;
    in_data  = d;
    do begin
      @(posedge clk); #1; t++;
    end while (!acc && t < 200);
    if (!acc) begin
      n_chk++; n_fail++;
      $display("FAIL send_timeout: word %0h never accepted, required acceptance", d);
    end
    in_valid = 1'b0;
    in_data  = $urandom;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    cycles(DEPTH + 1);
    out_ready = 1'b0;
  endtask

  initial begin
    // 1. reset release with valid held through reset
    in_valid = 1'b1;
    in_data  = 32'hAAAA_5555;
    cycles(3);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready_first", in_ready, 0);
    chk("rst_count", count, 0);
    chk("rst_out_valid", out_valid, 0);
    @(negedge clk);
    chk("rst_in_ready_second", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain();

    // 2. single word
    send(32'hDEAD_BEEF);
    @(negedge clk);
    chk("single_data", out_data, 32'hDEAD_BEEF);
    chk("single_count", count, 1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    cycles(1);
    out_ready = 1'b0;
    @(negedge clk);
    chk("single_empty_count", count, 0);
    chk("single_empty_valid", out_valid, 0);
    @(posedge clk); #1;

    // 3. fill, hold off 5th, pop once, drain
    for (int i = 1; i <= 4; i++) send(32'(i));
    @(negedge clk);
    chk("full_count", count, 4);
    chk("full_in_ready", in_ready, 0);
    @(posedge clk); #1;
    fork
      send(32'h5);
      begin
        cycles(2);
        out_ready = 1'b1;
        cycles(1);
        out_ready = 1'b0;
      end
    join
    @(negedge clk);
    chk("fill_head", out_data, 32'h2);
    chk("fill_count", count, 4);
    @(posedge clk); #1;
    drain();

    // 4. simultaneous push/pop at count=2 across pointer wrap
    send($urandom);
    send($urandom);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_data = $urandom;
      cycles(1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    chk("simul_count", count, 2);
    @(posedge clk); #1;
    drain();

    // 5. protocol error while full
    for (int i = 0; i < 4; i++) send($urandom);
    in_valid = 1'b1;
    in_data  = 32'hBAD0_0001;
    cycles(1);
    in_valid = 1'b0;
    @(negedge clk);
    chk("perr_not_yet", proto_err, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("perr_set", proto_err, 1);
    @(posedge clk); #1;
    done = 0;
    fork
      begin
        repeat (20) send($urandom);
        done = 1;
      end
      begin
        while (!done) begin
          out_ready = 1'($urandom_range(0, 1));
          cycles(1);
        end
        out_ready = 1'b0;
      end
    join
    @(negedge clk);
    chk("perr_sticky", proto_err, 1);
    @(posedge clk); #1;
    drain();

    // 6. reset mid-stream with 3 words buffered
    for (int i = 0; i < 3; i++) send(32'hC0DE_0000 + 32'(i));
    @(negedge clk);
    chk("mid_count_before", count, 3);
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    chk("mid_async_valid", out_valid, 0);
    chk("mid_async_count", count, 0);
    chk("mid_async_perr", proto_err, 0);
    #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    cycles(1);
    send(32'h0000_0077);
    @(negedge clk);
    chk("mid_new_data", out_data, 32'h0000_0077);
    chk("mid_new_count", count, 1);
    @(posedge clk); #1;
    drain();

    // random traffic with random consumer stalls
    done = 0;
    fork
      begin
        repeat (200) begin
          if ($urandom_range(0, 3) == 0) cycles($urandom_range(1, 3));
          send($urandom);
        end
        done = 1;
      end
      begin
        while (!done) begin
          out_ready = 1'($urandom_range(0, 1));
          cycles(1);
        end
        out_ready = 1'b0;
      end
    join
    drain();
    @(negedge clk);
    chk("final_empty", count, 0);
    chk("final_perr", proto_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    n_chk++; n_fail++;
    $display("FAIL watchdog: test still running at %0t, required completion", $time);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
